// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop synchronizer and centre-of-bit sampling.
// Latency: rx_valid/frame_err pulse one cycle after the stop-bit sample; no backpressure, pulses are not held.
module uart_rx #(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CNT_W    = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shreg, shreg_n;
  logic [7:0]       rx_data_n;
  logic             rx_valid_n, frame_err_n;

  logic rx_m, rx_s, rx_d;
  logic fall;

  // Flops preset high so that reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 1'b1;
    idx_n       = idx;
    shreg_n     = shreg;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    frame_err_n = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (en && fall) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          idx_n = '0;
          // A line that is high again at mid start bit was only a glitch.
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n          = '0;
          shreg_n[idx]   = rx_s;
          idx_n          = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) begin
            rx_data_n  = shreg;
            rx_valid_n = 1'b1;
          end else begin
            frame_err_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Disable drops any partial frame without reporting it.
    if (!en) begin
      state_n     = IDLE;
      cnt_n       = '0;
      idx_n       = '0;
      rx_data_n   = rx_data;
      rx_valid_n  = 1'b0;
      frame_err_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: line-level driver, pulse monitor, byte-queue reference model.
module tb_uart_rx;

  localparam int CLK_FREQ  = 25000000;
  localparam int BAUD_RATE = 115200;
  localparam int BIT       = CLK_FREQ / BAUD_RATE;   // 217 cycles per bit
  localparam int HALF      = BIT / 2;                // 108
  localparam int LAT_MIN   = HALF + 9 * BIT + 1;     // line fall -> pulse
  localparam int LAT_MAX   = HALF + 9 * BIT + 4;

  logic       clk = 1'b0;
  logic       rst_n, en, rx;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int both_cnt = 0;
  logic       busy_after;
  logic [10:0] snap;
  logic [7:0]  last_good;

  int         v_cyc[$];
  logic [7:0] v_dat[$];
  int         e_cyc[$];

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      v_dat.push_back(rx_data);
      v_cyc.push_back(cyc);
    end
    if (frame_err) e_cyc.push_back(cyc);
    if (rx_valid && frame_err) both_cnt++;
  end

  task automatic clear_mon();
    v_dat.delete();
    v_cyc.delete();
    e_cyc.delete();
  endtask

  // act: 0 none, 1 drop en mid data bit act_bit, 2 hold reset from mid data bit act_bit to frame end.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int act, input int act_bit);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      if (i == 0) fall_cyc = cyc;
      if (act != 0 && i == act_bit + 1) begin
        repeat (BIT / 2) @(negedge clk);
        if (act == 1) begin
          en = 1'b0;
          @(negedge clk);
          busy_after = busy;
        end else begin
          rst_n = 1'b0;
          #1;
          snap = {rx_data, rx_valid, frame_err, busy};
          @(negedge clk);
        end
        repeat (BIT - BIT / 2 - 1) @(negedge clk);
      end else begin
        repeat (BIT) @(negedge clk);
      end
    end
    if (act == 2) rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; rx = 1'b1;
    repeat (3) @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    nchk++; if (rx_data !== 8'h00) begin nfail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    nchk++; if (rx_valid !== 1'b0) begin nfail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    nchk++; if (frame_err !== 1'b0) begin nfail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL release_busy: got %b want 0", busy); end
    last_good = 8'h00;
  endtask

  task automatic check_one_byte(input string nm, input logic [7:0] exp);
    nchk++;
    if (v_dat.size() != 1 || e_cyc.size() != 0) begin
      nfail++;
      $display("FAIL %s_count: got %0d valid %0d ferr want 1/0", nm, v_dat.size(), e_cyc.size());
    end else begin
      nchk++; if (v_dat[0] !== exp) begin nfail++; $display("FAIL %s_data: got %h want %h", nm, v_dat[0], exp); end
      nchk++;
      if (v_cyc[0] - fall_cyc < LAT_MIN || v_cyc[0] - fall_cyc > LAT_MAX) begin
        nfail++;
        $display("FAIL %s_latency: got %0d want %0d..%0d", nm, v_cyc[0] - fall_cyc, LAT_MIN, LAT_MAX);
      end
    end
  endtask

  task automatic test_single_frames();
    logic [7:0] pat [7];
    pat[0] = 8'h55; pat[1] = 8'h00; pat[2] = 8'hFF; pat[3] = 8'hA3;
    for (int k = 4; k < 7; k++) pat[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 7; k++) begin
      clear_mon();
      send_frame(pat[k], 1'b1, 0, 0);
      repeat (BIT) @(negedge clk);
      check_one_byte("single", pat[k]);
      last_good = pat[k];
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(8'h12, 1'b1, 0, 0);
    send_frame(8'h34, 1'b1, 0, 0);
    repeat (BIT) @(negedge clk);
    nchk++;
    if (v_dat.size() != 2 || e_cyc.size() != 0) begin
      nfail++;
      $display("FAIL b2b_count: got %0d valid %0d ferr want 2/0", v_dat.size(), e_cyc.size());
    end else begin
      nchk++; if (v_dat[0] !== 8'h12) begin nfail++; $display("FAIL b2b_first: got %h want 12", v_dat[0]); end
      nchk++; if (v_dat[1] !== 8'h34) begin nfail++; $display("FAIL b2b_second: got %h want 34", v_dat[1]); end
      nchk++;
      if (v_cyc[1] - v_cyc[0] < 10 * BIT - 2 || v_cyc[1] - v_cyc[0] > 10 * BIT + 2) begin
        nfail++;
        $display("FAIL b2b_spacing: got %0d want %0d+/-2", v_cyc[1] - v_cyc[0], 10 * BIT);
      end
    end
    last_good = 8'h34;
  endtask

  task automatic test_glitch();
    int rise = -1;
    int low = -1;
    clear_mon();
    rx = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy && rise < 0) rise = cyc;
    end
    rx = 1'b1;
    for (int i = 0; i < 2 * BIT && low < 0; i++) begin
      @(negedge clk);
      if (!busy) low = cyc;
    end
    repeat (BIT) @(negedge clk);
    nchk++; if (rise < 0) begin nfail++; $display("FAIL glitch_busy_rise: got none want busy high"); end
    nchk++;
    if (low < 0 || low - rise > HALF + 3) begin
      nfail++;
      $display("FAIL glitch_busy_fall: got %0d cycles want <= %0d", low - rise, HALF + 3);
    end
    nchk++;
    if (v_dat.size() != 0 || e_cyc.size() != 0) begin
      nfail++;
      $display("FAIL glitch_pulses: got %0d valid %0d ferr want 0/0", v_dat.size(), e_cyc.size());
    end
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_frame(8'hC3, 1'b0, 0, 0);
    rx = 1'b0;
    repeat (5 * BIT) @(negedge clk);
    nchk++;
    if (e_cyc.size() != 1 || v_dat.size() != 0) begin
      nfail++;
      $display("FAIL ferr_count: got %0d ferr %0d valid want 1/0", e_cyc.size(), v_dat.size());
    end else begin
      nchk++;
      if (e_cyc[0] - fall_cyc < LAT_MIN || e_cyc[0] - fall_cyc > LAT_MAX) begin
        nfail++;
        $display("FAIL ferr_latency: got %0d want %0d..%0d", e_cyc[0] - fall_cyc, LAT_MIN, LAT_MAX);
      end
    end
    nchk++; if (rx_data !== last_good) begin nfail++; $display("FAIL ferr_hold: got %h want %h", rx_data, last_good); end
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    clear_mon();
    send_frame(8'h5A, 1'b1, 0, 0);
    repeat (BIT) @(negedge clk);
    check_one_byte("after_ferr", 8'h5A);
    last_good = 8'h5A;
  endtask

  task automatic test_en_drop();
    clear_mon();
    busy_after = 1'bx;
    send_frame(8'h96, 1'b1, 1, 3);
    repeat (BIT) @(negedge clk);
    en = 1'b1;
    repeat (BIT) @(negedge clk);
    nchk++; if (busy_after !== 1'b0) begin nfail++; $display("FAIL en_busy: got %b want 0", busy_after); end
    nchk++;
    if (v_dat.size() != 0 || e_cyc.size() != 0) begin
      nfail++;
      $display("FAIL en_pulses: got %0d valid %0d ferr want 0/0", v_dat.size(), e_cyc.size());
    end
    nchk++; if (rx_data !== last_good) begin nfail++; $display("FAIL en_hold: got %h want %h", rx_data, last_good); end
    clear_mon();
    send_frame(8'h3C, 1'b1, 0, 0);
    repeat (BIT) @(negedge clk);
    check_one_byte("after_en", 8'h3C);
    last_good = 8'h3C;
  endtask

  task automatic test_reset_mid();
    clear_mon();
    snap = 'x;
    send_frame(8'hE7, 1'b1, 2, 4);
    repeat (2 * BIT) @(negedge clk);
    nchk++;
    if (snap !== 11'h000) begin
      nfail++;
      $display("FAIL rst_mid_outputs: got data %h vld %b ferr %b busy %b want 00/0/0/0",
               snap[10:3], snap[2], snap[1], snap[0]);
    end
    nchk++;
    if (v_dat.size() != 0 || e_cyc.size() != 0) begin
      nfail++;
      $display("FAIL rst_mid_pulses: got %0d valid %0d ferr want 0/0", v_dat.size(), e_cyc.size());
    end
    nchk++; if (rx_data !== 8'h00) begin nfail++; $display("FAIL rst_mid_data: got %h want 00", rx_data); end
    clear_mon();
    send_frame(8'h81, 1'b1, 0, 0);
    repeat (BIT) @(negedge clk);
    check_one_byte("after_rst", 8'h81);
    last_good = 8'h81;
  endtask

  task automatic test_random_stream();
    logic [7:0] exp_q[$];
    int exp_err = 0;
    logic [7:0] d;
    logic bad;
    clear_mon();
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom_range(0, 255));
      bad = (k == 2) || ($urandom_range(0, 3) == 0);
      send_frame(d, !bad, 0, 0);
      if (bad) begin
        exp_err++;
        rx = 1'b1;
        repeat (BIT / 4 + $urandom_range(0, BIT / 2)) @(negedge clk);
      end else begin
        exp_q.push_back(d);
        repeat ($urandom_range(0, BIT)) @(negedge clk);
      end
    end
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    nchk++;
    if (e_cyc.size() != exp_err) begin
      nfail++;
      $display("FAIL rand_ferr_count: got %0d want %0d", e_cyc.size(), exp_err);
    end
    nchk++;
    if (v_dat.size() != exp_q.size()) begin
      nfail++;
      $display("FAIL rand_valid_count: got %0d want %0d", v_dat.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        nchk++;
        if (v_dat[i] !== exp_q[i]) begin
          nfail++;
          $display("FAIL rand_data[%0d]: got %h want %h", i, v_dat[i], exp_q[i]);
        end
      end
    end
    nchk++; if (both_cnt != 0) begin nfail++; $display("FAIL pulse_overlap: got %0d want 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_frames();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_en_drop();
    test_reset_mid();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 25000000, gives the system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, gives the serial bit rate in bit/s.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  receiver enable; while low, the block stays in IDLE.
REQ-006 rx  input  1  asynchronous serial line; idles high.
REQ-007 rx_data  output  8  last correctly framed byte, LSB received first.
REQ-008 rx_valid  output  1  one-cycle pulse: rx_data was updated this cycle.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 Define BIT_CYC = CLK_FREQ/BAUD_RATE, truncated to an integer (217 at defaults), and HALF_CYC = BIT_CYC/2, truncated (108).
- The bit counter shall be wide enough for BIT_CYC-1.
REQ-012 rx shall pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
- Falling-edge detection shall use rx_s and its 1-cycle delayed copy.
REQ-013 The FSM shall have states IDLE, START, DATA and STOP.
REQ-014 IDLE: on a detected falling edge of rx_s with en=1, go to START and clear the bit counter.
REQ-015 START: when the counter reaches HALF_CYC-1, sample rx_s.
- If 0, go to DATA with the counter cleared and bit index 0.
- If 1 (glitch), return to IDLE with no output pulse.
REQ-016 DATA: each time the counter reaches BIT_CYC-1, shift rx_s into the shift register at bit[index], LSB first, and clear the counter.
- After index 7 is sampled, go to STOP.
REQ-017 STOP: when the counter reaches BIT_CYC-1, sample rx_s and go to IDLE.
- If 1: load rx_data from the shift register and pulse rx_valid for exactly one cycle.
- If 0: pulse frame_err for one cycle and leave rx_data unchanged.
REQ-018 Sampling shall occur at the bit centre: the first data sample falls HALF_CYC+BIT_CYC cycles after the synchronized falling edge.
REQ-019 rx_valid shall be asserted in the cycle after the stop-bit sample.
- frame_err shall follow the same timing.
- rx_valid and frame_err shall never be high together.
REQ-020 A new start edge shall be accepted in the first IDLE cycle after STOP, so back-to-back frames are received without loss.
REQ-021 After a framing error, a new frame shall not start until rx_s has been seen high, because reception requires a falling edge.
- A continuous low (break) therefore yields exactly one frame_err.
REQ-022 en deasserted in any state shall force IDLE on the next clock edge.
- The partial byte is discarded, with no rx_valid and no frame_err.
- rx_data holds its value.
REQ-023 Edges on rx while not in IDLE shall be ignored except through the bit samples.

Reset
REQ-024 While rst_n=0, the block shall hold the following values:
- state IDLE, counter 0, index 0, shift register 0x00
- rx_data 0x00, rx_valid 0, frame_err 0, busy 0
- both synchronizer flops and the edge register set to 1, so no false edge appears on release.
REQ-025 Reset asserted mid-frame shall abort the frame immediately (asynchronously), with no output pulse.
- Reception resumes only on a fresh falling edge after release.

Verification
REQ-026 Defaults, en=1, send 0x55 (8680 ns/bit): rx_valid pulses once, rx_data=0x55, frame_err never asserts; repeat for 0x00, 0xFF and 0xA3.
REQ-027 Two frames back-to-back with no idle gap (0x12 then 0x34): two rx_valid pulses, data 0x12 then 0x34, with the pulses 10*BIT_CYC cycles apart, +/-2 cycles.
REQ-028 Low glitch on rx lasting 2000 ns (shorter than half a bit) in IDLE: busy returns low within HALF_CYC+3 cycles, and neither rx_valid nor frame_err asserts.
REQ-029 Frame 0xC3 with the stop bit driven low, then rx held low for 5 bit times: exactly one frame_err pulse, rx_data keeps its previous value, and the next valid frame 0x5A is received correctly.
REQ-030 en dropped during data bit 3 of a frame: busy is low on the next cycle and no pulse appears; rst_n pulsed low mid-frame: all outputs are at reset values and the following frame 0x81 is received correctly.
